// File: rtl/hot_addr_pull_pkg.sv
// Shared types and constants for the hot-address line puller.
// A line is 512 bits = 16 x 32-bit words. Bit 31 of each word is the line
// phase and bits 30:0 hold the PFN payload.
package hot_addr_pull_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AR      = 3'd1,
    RWAIT   = 3'd2,
    DRAIN   = 3'd3,
    BACKOFF = 3'd4
  } state_e;

  localparam int LINE_BYTES     = 64;
  localparam int WORD_BITS      = 32;
  localparam int PHASE_BIT      = 31;
  localparam int WORDS_PER_LINE = 16;
  localparam int LINE_BITS      = WORD_BITS * WORDS_PER_LINE;

  typedef struct packed {
    logic fresh;  // every phase bit equals the expected phase
    logic torn;   // phase bits disagree with each other
  } phase_chk_t;

  function automatic phase_chk_t line_phase_check(input logic [LINE_BITS-1:0] line,
                                                  input logic                 exp_phase);
    phase_chk_t r;
    logic all_one;
    logic all_zero;
    all_one  = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      if (line[i*WORD_BITS + PHASE_BIT]) all_zero = 1'b0;
      else                               all_one  = 1'b0;
    end
    r.fresh = exp_phase ? all_one : all_zero;
    r.torn  = !all_one && !all_zero;
    return r;
  endfunction

endpackage

// File: rtl/hot_addr_line_unpack.sv
// Holds one accepted line and streams its non-zero PFNs.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   load_i          capture line_i and start at word 0
//   line_i          512-bit line
//   pfn_valid_o     PFN available (valid/ready: transfer when both high at a
//                   clock edge; while valid is high without ready, pfn_o and
//                   valid stay stable)
//   pfn_o           {payload[30:0], 1'b0}
//   pfn_ready_i     consumer ready
//   done_o          pulses in the cycle word 15 is retired
module hot_addr_line_unpack
  import hot_addr_pull_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [LINE_BITS-1:0] line_i,
  output logic                 pfn_valid_o,
  output logic [31:0]          pfn_o,
  input  logic                 pfn_ready_i,
  output logic                 done_o
);

  logic [LINE_BITS-1:0] line_q, line_d;
  logic [3:0]           ptr_q, ptr_d;
  logic                 active_q, active_d;
  logic [31:0]          word;
  logic                 payload_zero;
  logic                 advance;
  logic                 last;
  logic                 unused_phase;

  assign word         = line_q[{ptr_q, 5'b0} +: WORD_BITS];
  assign payload_zero = (word[30:0] == 31'd0);
  // Zero words retire in one cycle without presenting anything downstream.
  assign advance      = active_q && (payload_zero || pfn_ready_i);
  assign last         = (ptr_q == 4'd15);
  assign done_o       = advance && last;
  assign pfn_valid_o  = active_q && !payload_zero;
  assign pfn_o        = active_q ? {word[30:0], 1'b0} : 32'd0;
  assign unused_phase = word[PHASE_BIT];

  always_comb begin
    line_d   = line_q;
    ptr_d    = ptr_q;
    active_d = active_q;
    if (load_i) begin
      line_d   = line_i;
      ptr_d    = 4'd0;
      active_d = 1'b1;
    end else if (advance) begin
      ptr_d = ptr_q + 4'd1;
      if (last) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q   <= '0;
      ptr_q    <= 4'd0;
      active_q <= 1'b0;
    end else begin
      line_q   <= line_d;
      ptr_q    <= ptr_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/hot_addr_pull.sv
// Polls a host ring of hot-address lines over a single-beat AXI4 read
// channel and streams fresh, non-zero PFNs to a consumer.
// Ports:
//   axi4_mm_clk/axi4_mm_rst_n   clock, async active-low reset
//   csr_enable                  run enable
//   csr_ring_base               byte address of line 0 (bits 5:0 ignored)
//   csr_aruser                  forwarded to hapl_aruser
//   hapl_ar*                    read address channel (one read outstanding)
//   hapl_r*                     read data channel (rid/rlast ignored)
//   pfn_valid/pfn/pfn_ready     PFN stream
//   lines_consumed_cnt          fresh lines fully drained (wraps)
//   stale_cnt                   stale or torn reads (wraps)
//   rresp_err_cnt               error responses (saturates)
// All handshakes are valid/ready: a transfer happens on a clock edge where
// both are high; a raised valid is held with stable payload until accepted.
module hot_addr_pull
  import hot_addr_pull_pkg::*;
#(
  parameter int NUM_LINES     = 25,
  parameter int POLL_INTERVAL = 256
) (
  input  logic                 axi4_mm_clk,
  input  logic                 axi4_mm_rst_n,
  input  logic                 csr_enable,
  input  logic [63:0]          csr_ring_base,
  input  logic [5:0]           csr_aruser,
  output logic [11:0]          hapl_arid,
  output logic [63:0]          hapl_araddr,
  output logic [5:0]           hapl_aruser,
  output logic                 hapl_arvalid,
  input  logic                 hapl_arready,
  input  logic [11:0]          hapl_rid,
  input  logic [LINE_BITS-1:0] hapl_rdata,
  input  logic [1:0]           hapl_rresp,
  input  logic                 hapl_rlast,
  input  logic                 hapl_rvalid,
  output logic                 hapl_rready,
  output logic                 pfn_valid,
  output logic [31:0]          pfn,
  input  logic                 pfn_ready,
  output logic [63:0]          lines_consumed_cnt,
  output logic [31:0]          stale_cnt,
  output logic [15:0]          rresp_err_cnt
);

  localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int BO_W  = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);
  localparam logic [BO_W-1:0]  BO_LOAD  = BO_W'(POLL_INTERVAL - 1);

  state_e           state_q;
  logic             arvalid_q;
  logic             rready_q;
  logic [63:0]      araddr_q;
  logic [IDX_W-1:0] line_idx_q, line_idx_d;
  logic             exp_phase_q;
  logic [BO_W-1:0]  backoff_q;
  logic [63:0]      lines_q;
  logic [31:0]      stale_q;
  logic [15:0]      err_q;
  phase_chk_t       chk;
  logic             load_line;
  logic             line_done;
  logic             unused_ok;

  function automatic logic [63:0] line_addr(input logic [63:0]      base,
                                            input logic [IDX_W-1:0] idx);
    return {base[63:6], 6'b0} + (64'(idx) * 64'(LINE_BYTES));
  endfunction

  assign chk        = line_phase_check(hapl_rdata, exp_phase_q);
  assign load_line  = (state_q == RWAIT) && hapl_rvalid && (hapl_rresp == 2'b00) && chk.fresh;
  assign line_idx_d = (line_idx_q == LAST_IDX) ? '0 : line_idx_q + 1'b1;
  assign unused_ok  = ^{hapl_rid, hapl_rlast, chk.torn};

  assign hapl_arid          = 12'd0;
  assign hapl_araddr        = araddr_q;
  assign hapl_aruser        = csr_aruser;
  assign hapl_arvalid       = arvalid_q;
  assign hapl_rready        = rready_q;
  assign lines_consumed_cnt = lines_q;
  assign stale_cnt          = stale_q;
  assign rresp_err_cnt      = err_q;

  hot_addr_line_unpack u_unpack (
    .clk_i       (axi4_mm_clk),
    .rst_ni      (axi4_mm_rst_n),
    .load_i      (load_line),
    .line_i      (hapl_rdata),
    .pfn_valid_o (pfn_valid),
    .pfn_o       (pfn),
    .pfn_ready_i (pfn_ready),
    .done_o      (line_done)
  );

  // The address is registered on entry to AR so it stays fixed until arready.
  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      state_q     <= IDLE;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      araddr_q    <= 64'd0;
      line_idx_q  <= '0;
      exp_phase_q <= 1'b0;
      backoff_q   <= '0;
      lines_q     <= 64'd0;
      stale_q     <= 32'd0;
      err_q       <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (csr_enable) begin
            state_q   <= AR;
            arvalid_q <= 1'b1;
            araddr_q  <= line_addr(csr_ring_base, line_idx_q);
          end
        end
        AR: begin
          if (hapl_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RWAIT;
          end
        end
        RWAIT: begin
          if (hapl_rvalid) begin
            rready_q <= 1'b0;
            if (hapl_rresp != 2'b00) begin
              if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
              backoff_q <= BO_LOAD;
              state_q   <= BACKOFF;
            end else if (chk.fresh) begin
              state_q <= DRAIN;
            end else begin
              stale_q   <= stale_q + 32'd1;
              backoff_q <= BO_LOAD;
              state_q   <= BACKOFF;
            end
          end
        end
        DRAIN: begin
          if (line_done) begin
            line_idx_q  <= line_idx_d;
            exp_phase_q <= ~exp_phase_q;
            lines_q     <= lines_q + 64'd1;
            if (csr_enable) begin
              state_q   <= AR;
              arvalid_q <= 1'b1;
              araddr_q  <= line_addr(csr_ring_base, line_idx_d);
            end else begin
              state_q <= IDLE;
            end
          end
        end
        BACKOFF: begin
          if (backoff_q == '0) begin
            if (csr_enable) begin
              state_q   <= AR;
              arvalid_q <= 1'b1;
              araddr_q  <= line_addr(csr_ring_base, line_idx_q);
            end else begin
              state_q <= IDLE;
            end
          end else begin
            backoff_q <= backoff_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hot_addr_pull.sv
module tb_hot_addr_pull;

  logic         clk;
  logic         rst_n;
  logic         csr_enable;
  logic [63:0]  csr_ring_base;
  logic [5:0]   csr_aruser;
  logic [11:0]  hapl_arid;
  logic [63:0]  hapl_araddr;
  logic [5:0]   hapl_aruser;
  logic         hapl_arvalid;
  logic         hapl_arready;
  logic [11:0]  hapl_rid;
  logic [511:0] hapl_rdata;
  logic [1:0]   hapl_rresp;
  logic         hapl_rlast;
  logic         hapl_rvalid;
  logic         hapl_rready;
  logic         pfn_valid;
  logic [31:0]  pfn;
  logic         pfn_ready;
  logic [63:0]  lines_consumed_cnt;
  logic [31:0]  stale_cnt;
  logic [15:0]  rresp_err_cnt;

  localparam logic [63:0] BASE = 64'h1_0000_0000;

  int          tests_run = 0;
  int          failures  = 0;
  logic [31:0] exp_q[$];
  logic [30:0] pay [16];
  int          tb_idx    = 0;
  logic        tb_phase  = 1'b0;
  logic [63:0] tb_lines  = 64'd0;

  hot_addr_pull #(.NUM_LINES(25), .POLL_INTERVAL(256)) dut (
    .axi4_mm_clk        (clk),
    .axi4_mm_rst_n      (rst_n),
    .csr_enable         (csr_enable),
    .csr_ring_base      (csr_ring_base),
    .csr_aruser         (csr_aruser),
    .hapl_arid          (hapl_arid),
    .hapl_araddr        (hapl_araddr),
    .hapl_aruser        (hapl_aruser),
    .hapl_arvalid       (hapl_arvalid),
    .hapl_arready       (hapl_arready),
    .hapl_rid           (hapl_rid),
    .hapl_rdata         (hapl_rdata),
    .hapl_rresp         (hapl_rresp),
    .hapl_rlast         (hapl_rlast),
    .hapl_rvalid        (hapl_rvalid),
    .hapl_rready        (hapl_rready),
    .pfn_valid          (pfn_valid),
    .pfn                (pfn),
    .pfn_ready          (pfn_ready),
    .lines_consumed_cnt (lines_consumed_cnt),
    .stale_cnt          (stale_cnt),
    .rresp_err_cnt      (rresp_err_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] line_addr(input int idx);
    return BASE + 64'(idx) * 64'd64;
  endfunction

  function automatic logic [511:0] pack_line(input logic [15:0] phases);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = {phases[i], pay[i]};
    return l;
  endfunction

  task automatic push_expected();
    for (int i = 0; i < 16; i++)
      if (pay[i] != 31'd0) exp_q.push_back({pay[i], 1'b0});
  endtask

  task automatic random_payloads();
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 5) == 0) pay[i] = 31'd0;
      else                           pay[i] = 31'($urandom_range(1, 32'h7FFF_FFFF));
    end
  endtask

  // driver: accept one AR at exp_addr, then return one R beat.
  // Returns at the negedge right after the R beat was captured.
  task automatic serve_read(input logic [63:0] exp_addr, input logic [511:0] data,
                            input logic [1:0] resp);
    int n;
    n = 0;
    hapl_arready = 1'b1;
    while (!hapl_arvalid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (!hapl_arvalid) begin
      failures++;
      $display("FAIL ar_timeout: arvalid=%0b after %0d cycles, required 1", hapl_arvalid, n);
      hapl_arready = 1'b0;
    end else begin
      tests_run++;
      if (hapl_araddr !== exp_addr) begin
        failures++;
        $display("FAIL araddr: got %h required %h", hapl_araddr, exp_addr);
      end
      @(negedge clk);
      hapl_arready = 1'b0;
      tests_run++;
      if (hapl_rready !== 1'b1 || hapl_arvalid !== 1'b0) begin
        failures++;
        $display("FAIL rwait: rready=%0b arvalid=%0b required 1/0", hapl_rready, hapl_arvalid);
      end
      hapl_rdata  = data;
      hapl_rresp  = resp;
      hapl_rvalid = 1'b1;
      @(negedge clk);
      hapl_rvalid = 1'b0;
    end
  endtask

  // Count cycles until arvalid rises; report any pfn_valid seen meanwhile.
  task automatic wait_backoff(output int n, output logic saw_valid);
    n = 0;
    saw_valid = 1'b0;
    while (!hapl_arvalid && n < 1000) begin
      if (pfn_valid) saw_valid = 1'b1;
      @(negedge clk);
      n++;
    end
  endtask

  // scoreboard: pop and compare each PFN handshake until the line is consumed.
  // mode 0: ready always; 1: random ready; 2: stalled 5 cycles then random.
  task automatic drain_line(input int mode, output int cycles, output int hs);
    logic        prev_stall;
    logic [31:0] prev_pfn;
    logic [31:0] e;
    int n;
    n = 0;
    hs = 0;
    prev_stall = 1'b0;
    prev_pfn = 32'd0;
    while (lines_consumed_cnt !== tb_lines + 64'd1 && n < 400) begin
      case (mode)
        0:       pfn_ready = 1'b1;
        1:       pfn_ready = ($urandom_range(0, 3) != 0);
        default: pfn_ready = (n >= 5) && ($urandom_range(0, 2) != 0);
      endcase
      if (prev_stall) begin
        tests_run++;
        if (pfn_valid !== 1'b1 || pfn !== prev_pfn) begin
          failures++;
          $display("FAIL pfn_hold: valid=%0b pfn=%h required 1/%h", pfn_valid, pfn, prev_pfn);
        end
      end
      if (pfn_valid && pfn_ready) begin
        tests_run++;
        hs++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pfn_extra: got %h, none expected", pfn);
        end else begin
          e = exp_q.pop_front();
          if (pfn !== e) begin
            failures++;
            $display("FAIL pfn_data: got %h required %h", pfn, e);
          end
        end
      end
      prev_stall = pfn_valid && !pfn_ready;
      prev_pfn   = pfn;
      n++;
      @(negedge clk);
    end
    pfn_ready = 1'b0;
    cycles = n;
    tb_lines = tb_lines + 64'd1;
    tests_run++;
    if (lines_consumed_cnt !== tb_lines) begin
      failures++;
      $display("FAIL lines_consumed: got %0d required %0d", lines_consumed_cnt, tb_lines);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pfn_missing: %0d PFNs never delivered, required 0", exp_q.size());
    end
    exp_q.delete();
    tb_idx   = (tb_idx + 1) % 25;
    tb_phase = ~tb_phase;
  endtask

  task automatic fresh_line(input int mode);
    int cyc, hs;
    push_expected();
    serve_read(line_addr(tb_idx), pack_line({16{tb_phase}}), 2'b00);
    drain_line(mode, cyc, hs);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (hapl_arvalid !== 1'b0 || hapl_rready !== 1'b0 || pfn_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake: arvalid=%0b rready=%0b pfn_valid=%0b required 0",
               hapl_arvalid, hapl_rready, pfn_valid);
    end
    tests_run++;
    if (hapl_araddr !== 64'd0 || hapl_arid !== 12'd0 || pfn !== 32'd0) begin
      failures++;
      $display("FAIL reset_data: araddr=%h arid=%h pfn=%h required 0", hapl_araddr, hapl_arid, pfn);
    end
    tests_run++;
    if (lines_consumed_cnt !== 64'd0 || stale_cnt !== 32'd0 || rresp_err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_counters: lines=%0d stale=%0d err=%0d required 0",
               lines_consumed_cnt, stale_cnt, rresp_err_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    csr_enable = 1'b1;
    @(negedge clk);
    tests_run++;
    if (hapl_aruser !== 6'h2A || hapl_arid !== 12'd0) begin
      failures++;
      $display("FAIL aruser_arid: aruser=%h arid=%h required 2a/000", hapl_aruser, hapl_arid);
    end
    for (int i = 0; i < 16; i++) pay[i] = 31'h1000 + 31'(i);
    fresh_line(0);
  endtask

  task automatic test_stale_backoff();
    int   n;
    logic sv;
    for (int i = 0; i < 16; i++) pay[i] = 31'h5000 + 31'(i * 7);
    serve_read(line_addr(1), pack_line({16{~tb_phase}}), 2'b00);
    tests_run++;
    if (stale_cnt !== 32'd1) begin
      failures++;
      $display("FAIL stale_cnt: got %0d required 1", stale_cnt);
    end
    wait_backoff(n, sv);
    tests_run++;
    if (n != 256) begin
      failures++;
      $display("FAIL backoff_len: got %0d cycles required 256", n);
    end
    tests_run++;
    if (sv !== 1'b0) begin
      failures++;
      $display("FAIL stale_output: pfn_valid seen=%0b required 0", sv);
    end
    fresh_line(1);
  endtask

  task automatic test_zero_skip();
    int cyc, hs;
    for (int i = 0; i < 16; i++) pay[i] = 31'h7000_0000 + 31'(i * 3 + 1);
    pay[3] = 31'd0;
    pay[9] = 31'd0;
    push_expected();
    serve_read(line_addr(tb_idx), pack_line({16{tb_phase}}), 2'b00);
    drain_line(0, cyc, hs);
    tests_run++;
    if (hs != 14) begin
      failures++;
      $display("FAIL zero_skip_hs: got %0d handshakes required 14", hs);
    end
    tests_run++;
    if (cyc != 16) begin
      failures++;
      $display("FAIL drain_cycles: got %0d required 16", cyc);
    end
  endtask

  task automatic test_torn_and_error();
    int   n;
    logic sv;
    random_payloads();
    serve_read(line_addr(tb_idx), pack_line(tb_phase ? 16'h00FF : 16'hFF00), 2'b00);
    tests_run++;
    if (stale_cnt !== 32'd2) begin
      failures++;
      $display("FAIL torn_stale_cnt: got %0d required 2", stale_cnt);
    end
    wait_backoff(n, sv);
    tests_run++;
    if (sv !== 1'b0 || n != 256) begin
      failures++;
      $display("FAIL torn_backoff: pfn_valid seen=%0b cycles=%0d required 0/256", sv, n);
    end
    serve_read(line_addr(tb_idx), pack_line({16{tb_phase}}), 2'b10);
    tests_run++;
    if (rresp_err_cnt !== 16'd1 || stale_cnt !== 32'd2) begin
      failures++;
      $display("FAIL rresp_err: err=%0d stale=%0d required 1/2", rresp_err_cnt, stale_cnt);
    end
    wait_backoff(n, sv);
    tests_run++;
    if (sv !== 1'b0 || n != 256) begin
      failures++;
      $display("FAIL err_backoff: pfn_valid seen=%0b cycles=%0d required 0/256", sv, n);
    end
    fresh_line(1);
  endtask

  task automatic test_wrap();
    while (tb_idx != 0) begin
      random_payloads();
      fresh_line($urandom_range(0, 1));
    end
    // Second visit of line 0: 25 toggles leave the expected phase at 1.
    random_payloads();
    pay[0] = 31'h0ABC_DEF0;
    fresh_line(0);
    tests_run++;
    if (lines_consumed_cnt !== 64'd26) begin
      failures++;
      $display("FAIL wrap_lines: got %0d required 26", lines_consumed_cnt);
    end
  endtask

  task automatic test_enable_drop();
    int cyc, hs, ar_seen;
    random_payloads();
    pay[15] = 31'h1234_5678;
    push_expected();
    serve_read(line_addr(tb_idx), pack_line({16{tb_phase}}), 2'b00);
    csr_enable = 1'b0;
    drain_line(2, cyc, hs);
    ar_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (hapl_arvalid) ar_seen++;
      @(negedge clk);
    end
    tests_run++;
    if (ar_seen != 0) begin
      failures++;
      $display("FAIL enable_drop_ar: arvalid high %0d cycles required 0", ar_seen);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    hapl_arready = 1'b0;
    csr_enable = 1'b1;
    n = 0;
    while (!hapl_arvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (hapl_arvalid !== 1'b1 || hapl_araddr !== line_addr(tb_idx)) begin
      failures++;
      $display("FAIL resume_ar: arvalid=%0b araddr=%h required 1/%h",
               hapl_arvalid, hapl_araddr, line_addr(tb_idx));
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (hapl_arvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_arvalid: got %0b required 0", hapl_arvalid);
    end
    tests_run++;
    if (lines_consumed_cnt !== 64'd0 || stale_cnt !== 32'd0 || rresp_err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_counters: lines=%0d stale=%0d err=%0d required 0",
               lines_consumed_cnt, stale_cnt, rresp_err_cnt);
    end
    csr_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    csr_enable    = 1'b0;
    csr_ring_base = BASE | 64'h2A;  // low bits must be ignored
    csr_aruser    = 6'h2A;
    hapl_arready  = 1'b0;
    hapl_rid      = 12'h5A5;
    hapl_rdata    = '0;
    hapl_rresp    = 2'b00;
    hapl_rlast    = 1'b1;
    hapl_rvalid   = 1'b0;
    pfn_ready     = 1'b0;

    test_reset();
    test_basic();
    test_stale_backoff();
    test_zero_skip();
    test_torn_and_error();
    test_wrap();
    test_enable_drop();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/hot_addr_pull.md
Name: hot_addr_pull

Overview:
- Device-side reader for the hot-address line format: 512-bit lines, each holding 16 x 32-bit words; word bit 31 is the line phase, bits 30:0 are the PFN payload.
- Polls a host-memory ring of such lines over a single-beat AXI4 read channel.
- Accepts a line only when its phase matches the expected phase, then streams the non-zero PFNs one per handshake to a downstream consumer (migration/prefetch engine).

Parameters:
- NUM_LINES, 25, number of 64B lines in the host ring; index wraps to 0 after NUM_LINES-1.
- WORDS_PER_LINE, 16, 32-bit words per 512-bit line; fixed by the line format.
- POLL_INTERVAL, 256, backoff cycles after a stale/torn/error read before re-reading the same line; must be >= 1.

Ports:
- axi4_mm_clk  in  1  clock.
- axi4_mm_rst_n  in  1  asynchronous active-low reset.
- csr_enable  in  1  run enable; sampled each cycle.
- csr_ring_base  in  64  byte address of line 0; bits 5:0 are ignored (treated as 0).
- csr_aruser  in  6  driven onto hapl_aruser.
- hapl_arid  out  12  constant 0.
- hapl_araddr  out  64  line read address.
- hapl_aruser  out  6  from csr_aruser.
- hapl_arvalid  out  1  read request valid.
- hapl_arready  in  1  read request ready.
- hapl_rid  in  12  ignored.
- hapl_rdata  in  512  line data.
- hapl_rresp  in  2  00 = OKAY; anything else is an error.
- hapl_rlast  in  1  ignored; single beat.
- hapl_rvalid  in  1  read data valid.
- hapl_rready  out  1  read data ready.
- pfn_valid  out  1  output PFN valid.
- pfn  out  32  {payload[30:0], 1'b0}.
- pfn_ready  in  1  consumer ready.
- lines_consumed_cnt  out  64  fresh lines fully drained.
- stale_cnt  out  32  stale or torn reads.
- rresp_err_cnt  out  16  error responses; saturates.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, line_idx=0, exp_phase=0, all counters 0.
- At most one read outstanding.
- hapl_araddr = {csr_ring_base[63:6],6'b0} + line_idx*64, 64-bit wrap.
- States:
  - IDLE: arvalid=0. If csr_enable -> AR.
  - AR: arvalid=1, held with stable address until arready. Then go to RWAIT.
  - RWAIT: rready=1. On rvalid, handled in priority order:
    - rresp!=0: rresp_err_cnt++ (saturating), -> BACKOFF.
    - All 16 phase bits == exp_phase: latch rdata, word_ptr=0 -> DRAIN.
    - Otherwise (stale line, or phase bits mixed = torn): stale_cnt++ -> BACKOFF.
  - DRAIN: current word w = line[word_ptr*32 +: 32].
    - If w[30:0]==0: pfn_valid=0, word_ptr++ in the same cycle (one cycle per skipped word).
    - Else: pfn_valid=1, pfn held stable until pfn_ready, then word_ptr++.
    - On advancing past word 15: line_idx wraps at NUM_LINES, exp_phase toggles, lines_consumed_cnt++. Next state is AR if csr_enable, else IDLE.
  - BACKOFF: counter loads POLL_INTERVAL-1 and decrements. At 0: -> AR if csr_enable, else IDLE. line_idx and exp_phase are unchanged, so the same line is re-read.
- Enable drop mid-operation: current AR/RWAIT/DRAIN completes and the line is fully drained. Then IDLE; line_idx and exp_phase are retained. AR never withdraws arvalid once asserted.
- Output rules:
  - pfn_valid may assert one cycle after the rvalid capture.
  - pfn_valid never deasserts without a handshake.
  - Back-to-back PFN handshakes are allowed: 1 word/cycle.
- lines_consumed_cnt and stale_cnt wrap.

Decomposition:
- Package hot_addr_pull_pkg holds:
  - state enum {IDLE, AR, RWAIT, DRAIN, BACKOFF};
  - LINE_BYTES=64, WORD_BITS=32, PHASE_BIT=31, WORDS_PER_LINE=16;
  - function line_phase_check(line, exp) returning {fresh, torn}.
- Sub-module hot_addr_line_unpack: line register, word_ptr, zero-skip logic and the pfn valid/ready port. Inputs are load and line; output is done, pulsed after word 15.
- The top level holds the FSM, AXI channel, ring index/phase, backoff timer and counters.

Test Plan:
- Base 0x1_0000_0000; line 0 words = {1'b0, 31'h1000+i}, arready/rready immediate -> araddr 0x1_0000_0000; 16 PFNs 0x2000, 0x2002, ... 0x201E in order; lines_consumed_cnt=1; next araddr 0x1_0000_0040.
- Line 1 returned with phase 0 (stale, expected 1) -> stale_cnt=1; no pfn_valid; re-read of 0x..0040 issued exactly POLL_INTERVAL=256 cycles after the rvalid cycle. Phase-1 data on retry -> 16 PFNs.
- Line with words 3 and 9 payload 0 and pfn_ready always 1 -> exactly 14 PFN handshakes; DRAIN takes 16 cycles.
- Torn line (words 0-7 phase 1, words 8-15 phase 0) -> stale_cnt++, no output. rresp=2'b10 -> rresp_err_cnt=1, BACKOFF, same address re-read.
- Consume 25 fresh lines -> line_idx wraps to 0 and address returns to base. Expected phase for the second visit to line 0 is 1 (25 toggles).
- Reset mid-operation: assert reset while AR has arvalid high and arready low -> arvalid drops immediately and all counters read 0. csr_enable deasserted during DRAIN with pfn_ready stalled -> line still fully drained, then IDLE with no new AR.
